// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core definitions: data width, NOP encoding, fetch FSM
//               states and immediate-select codes used by decoder/imm_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] c_nop_inst = 32'h0000_0013;

  localparam logic [XLEN-1:0] c_inst_bytes = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_sel_e;

  // Sequential next PC; wraps modulo 2^XLEN by construction.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc_cur);
    return pc_cur + c_inst_bytes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction-memory, downstream and redirect signals of the
//               fetch stage. fetch_misaligned exists only when
//               INST_FETCH_MISALIGN_CHK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic            inst_valid;
  logic            inst_ready;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic            fetch_misaligned;
`endif

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata,
    output inst,
    output pc,
    output inst_valid,
    input  inst_ready,
    input  redirect_valid,
    input  redirect_target
`ifdef INST_FETCH_MISALIGN_CHK_EN
    ,
    output fetch_misaligned
`endif
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata,
    input  inst,
    input  pc,
    input  inst_valid,
    output inst_ready,
    output redirect_valid,
    output redirect_target
`ifdef INST_FETCH_MISALIGN_CHK_EN
    ,
    input  fetch_misaligned
`endif
  );

endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Fetch stage: PC register, single-request instruction fetch and
//               valid/ready hand-off with redirect. Optional misaligned-redirect
//               trap enabled by INST_FETCH_MISALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  wire logic       clk,
  input  wire logic       rst,
  inst_fetch_if.master    bus
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic            r_imem_req;
  logic            r_inst_valid;
  logic            w_redirect;

`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic            r_fetch_misaligned;
  logic            w_misaligned;

  // A halted stage no longer responds to redirects; only rst recovers it.
  assign w_redirect   = bus.redirect_valid && (r_state != HALT);
  assign w_misaligned = (bus.redirect_target[1:0] != 2'b00);
`else
  assign w_redirect   = bus.redirect_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_inst       <= c_nop_inst;
      r_imem_req   <= 1'b1;
      r_inst_valid <= 1'b0;
`ifdef INST_FETCH_MISALIGN_CHK_EN
      r_fetch_misaligned <= 1'b0;
`endif
    end else if (w_redirect) begin
      // Any response or handshake in this cycle is superseded by the redirect.
`ifdef INST_FETCH_MISALIGN_CHK_EN
      if (w_misaligned) begin
        r_state            <= HALT;
        r_imem_req         <= 1'b0;
        r_inst_valid       <= 1'b0;
        r_fetch_misaligned <= 1'b1;
      end else begin
        r_state      <= FETCH;
        r_pc         <= bus.redirect_target;
        r_imem_req   <= 1'b1;
        r_inst_valid <= 1'b0;
      end
`else
      r_state      <= FETCH;
      r_pc         <= bus.redirect_target;
      r_imem_req   <= 1'b1;
      r_inst_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.imem_ready) begin
            r_inst       <= bus.imem_rdata;
            r_state      <= VALID;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b1;
          end
        end
        VALID: begin
          if (bus.inst_ready) begin
            r_pc         <= pc_next(r_pc);
            r_state      <= FETCH;
            r_imem_req   <= 1'b1;
            r_inst_valid <= 1'b0;
          end
        end
`ifdef INST_FETCH_MISALIGN_CHK_EN
        HALT: begin
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
        end
`endif
        default: begin
          r_state      <= FETCH;
          r_imem_req   <= 1'b1;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.inst       = r_inst;
  assign bus.pc         = r_pc;
  assign bus.inst_valid = r_inst_valid;
`ifdef INST_FETCH_MISALIGN_CHK_EN
  assign bus.fetch_misaligned = r_fetch_misaligned;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch with an instruction
//               scoreboard and a reference PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .XLEN     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] m_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DUT expected in FETCH at m_pc; memory answers after 'waits' wait states.
  task automatic do_fetch(input int waits, input logic [31:0] word);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h",
               bus.imem_req, bus.imem_addr, m_pc);
    end
    for (int i = 0; i < waits; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = ~word;
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_state: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                 bus.imem_req, bus.imem_addr, bus.inst_valid, m_pc);
      end
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    sb.push_back('{inst: word, pc: m_pc});
    tick();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL valid_rise: valid=%b req=%b, expected valid=1 req=0",
               bus.inst_valid, bus.imem_req);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got inst=%h pc=%h, expected a queued entry",
               bus.inst, bus.pc);
    end else begin
      cur = sb.pop_front();
      if (bus.inst !== cur.inst || bus.pc !== cur.pc) begin
        errors++;
        $display("FAIL inst_out: inst=%h pc=%h, expected inst=%h pc=%h",
                 bus.inst, bus.pc, cur.inst, cur.pc);
      end
    end
  endtask

  // DUT expected in VALID; downstream stalls 'stall' cycles then accepts.
  task automatic do_accept(input int stall);
    for (int i = 0; i < stall; i++) begin
      bus.inst_ready = 1'b0;
      tick();
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0 ||
          bus.inst !== cur.inst || bus.pc !== cur.pc) begin
        errors++;
        $display("FAIL hold: valid=%b req=%b inst=%h pc=%h, expected valid=1 req=0 inst=%h pc=%h",
                 bus.inst_valid, bus.imem_req, bus.inst, bus.pc, cur.inst, cur.pc);
      end
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    m_pc = m_pc + 32'd4;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
               bus.imem_req, bus.imem_addr, bus.inst_valid, m_pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    m_pc = 32'h0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.inst_valid !== 1'b0 || bus.pc !== 32'h0 ||
        bus.imem_addr !== 32'h0 || bus.inst !== 32'h0000_0013) begin
      errors++;
      $display("FAIL reset: req=%b valid=%b pc=%h addr=%h inst=%h, expected 1 0 0 0 00000013",
               bus.imem_req, bus.inst_valid, bus.pc, bus.imem_addr, bus.inst);
    end
`ifdef INST_FETCH_MISALIGN_CHK_EN
    checks++;
    if (bus.fetch_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_misaligned: got %b expected 0", bus.fetch_misaligned);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_fetch(0, 32'h0050_0093);
    do_accept(0);
  endtask

  task automatic test_wait_states();
    do_fetch(3, 32'h0010_8113);
    do_accept(0);
  endtask

  task automatic test_backpressure();
    do_fetch(0, 32'h0020_0193);
    do_accept(5);
  endtask

  task automatic test_redirect_fetch();
    bus.imem_ready      = 1'b1;
    bus.imem_rdata      = 32'hDEAD_BEEF;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0100;
    tick();
    bus.imem_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    m_pc = 32'h0000_0100;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
      errors++;
      $display("FAIL redirect_fetch: valid=%b req=%b addr=%h, expected 0 1 %h",
               bus.inst_valid, bus.imem_req, bus.imem_addr, m_pc);
    end
    tick();
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_addr !== m_pc) begin
      errors++;
      $display("FAIL redirect_drop: valid=%b addr=%h, expected 0 %h",
               bus.inst_valid, bus.imem_addr, m_pc);
    end
    do_fetch(1, 32'h0040_0213);
    do_accept(0);
  endtask

  task automatic test_redirect_valid();
    do_fetch(0, 32'h0000_006F);
    bus.inst_ready      = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    tick();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    m_pc = 32'h0000_0200;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
      errors++;
      $display("FAIL redirect_valid: valid=%b req=%b addr=%h, expected 0 1 %h",
               bus.inst_valid, bus.imem_req, bus.imem_addr, m_pc);
    end
  endtask

  task automatic test_wrap();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    m_pc = 32'hFFFF_FFFC;
    do_fetch(0, 32'h0000_0513);
    do_accept(0);
    checks++;
    if (bus.imem_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h expected 00000000", bus.imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      do_fetch(0, 32'h1000_0000 + k);
      do_accept(0);
    end
  endtask

  task automatic test_reset_priority();
    rst                 = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0400;
    tick();
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    m_pc = 32'h0;
    checks++;
    if (bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority: addr=%h valid=%b req=%b, expected 0 0 1",
               bus.imem_addr, bus.inst_valid, bus.imem_req);
    end
  endtask

`ifdef INST_FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0102;
    tick();
    checks++;
    if (bus.fetch_misaligned !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_set: mis=%b req=%b valid=%b, expected 1 0 0",
               bus.fetch_misaligned, bus.imem_req, bus.inst_valid);
    end
    bus.redirect_target = 32'h0000_0200;
    bus.imem_ready      = 1'b1;
    bus.inst_ready      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.fetch_misaligned !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold: mis=%b req=%b valid=%b, expected 1 0 0",
                 bus.fetch_misaligned, bus.imem_req, bus.inst_valid);
      end
    end
    bus.redirect_valid = 1'b0;
    bus.imem_ready     = 1'b0;
    bus.inst_ready     = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc = 32'h0;
    checks++;
    if (bus.fetch_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: mis=%b expected 0", bus.fetch_misaligned);
    end
    do_fetch(0, 32'h0050_0093);
    do_accept(0);
  endtask
`else
  task automatic test_unaligned_redirect();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0102;
    tick();
    bus.redirect_valid = 1'b0;
    m_pc = 32'h0000_0102;
    do_fetch(0, 32'h0000_0013);
    do_accept(0);
  endtask
`endif

  initial begin
    bus.imem_ready      = 1'b0;
    bus.imem_rdata      = 32'h0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    m_pc = 32'h0;

    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_redirect_fetch();
    test_redirect_valid();
    test_wrap();
    test_back_to_back();
    test_reset_priority();
`ifdef INST_FETCH_MISALIGN_CHK_EN
    test_misalign();
`else
    test_unaligned_redirect();
`endif

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage directly upstream of the immediate generator and control decoder in the RISC-V core.
- Holds the program counter and requests 32-bit instructions from instruction memory, which may insert wait states.
- Presents one instruction plus its PC downstream with a valid/ready handshake.
- Accepts a redirect (branch/jump target) that overrides sequential fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, address/instruction width; fixed at 32.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address.
- imem_ready  input  1  imem_rdata valid for the imem_addr presented this cycle.
- imem_rdata  input  32  instruction word.
- inst  output  32  registered instruction to decoder/imm_gen.
- pc  output  32  address of inst.
- inst_valid  output  1  inst/pc valid.
- inst_ready  input  1  downstream accepts inst this cycle.
- redirect_valid  input  1  redirect request.
- redirect_target  input  32  new PC.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=FETCH, pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0. imem_req=1 from the first cycle after reset.
- FETCH state:
  - imem_req=1, imem_addr=pc, inst_valid=0.
  - If imem_ready=1: inst<=imem_rdata; go to VALID.
  - imem_ready while imem_req=0 is ignored.
- VALID state:
  - imem_req=0, inst_valid=1.
  - inst and pc are held stable until the handshake.
  - If inst_ready=1: pc<=pc+4; go to FETCH.
- Latency and throughput:
  - Zero-wait memory: response captured in cycle N, inst_valid in N+1.
  - Minimum 2 cycles per instruction.
  - Each wait state adds one cycle.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Redirect (highest priority, either state):
  - pc<=redirect_target; state<=FETCH; inst_valid=0 next cycle.
  - In FETCH, an imem_ready in the same cycle is discarded.
  - In VALID, a simultaneous inst_ready handshake is still counted as consumed by downstream, but pc takes redirect_target, not pc+4.
- rst has priority over redirect_valid.
- rst mid-fetch abandons the request. Memory has no outstanding transactions beyond the current cycle.
- redirect_target[1:0] is not checked unless the optional feature is compiled in.

Optional Feature:
- Macro: INST_FETCH_MISALIGN_CHK_EN.
- When defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with target[1:0]!=0 sets fetch_misaligned sticky until rst; state goes to HALT.
  - HALT: imem_req=0, inst_valid=0; only rst leaves it.
- When undefined: no port, no HALT state; target is used as-is.

Decomposition:
- Shared package riscv_pkg: XLEN, NOP encoding 32'h0000_0013, fetch state enum (FETCH, VALID, HALT), immediate-select codes R/I/S/B/U/J already used by the decoder/imm_gen.
- No sub-module; the PC incrementer and next-PC mux stay inline.

Test Plan:
1. Reset release, RESET_PC=0, zero-wait memory returning 0x00500093 -> cycle 1: imem_addr=0, imem_req=1; cycle 2: inst_valid=1, inst=0x00500093, pc=0.
2. imem_ready low for 3 cycles -> imem_addr held at 0x4 throughout; inst_valid rises 1 cycle after imem_ready.
3. inst_ready low 5 cycles in VALID -> inst/pc unchanged, imem_req=0; on inst_ready=1, next imem_addr=pc+4.
4. redirect_valid with target 0x100 in the same cycle as imem_ready -> response dropped, next imem_addr=0x100, inst_valid=0.
5. pc=0xFFFFFFFC handshake -> next imem_addr=0x00000000.
6. (INST_FETCH_MISALIGN_CHK_EN) redirect to 0x102 -> fetch_misaligned=1, imem_req=0 permanently; rst clears both and fetch resumes at RESET_PC.
